input_bit_serializer: RTL and testbench

Feeds the DCIM macro with activations bit-serially, MSB plane first. This matches the shift-left-then-add order used by the global accumulator. It accepts one parallel activation vector per operation through a valid/ready handshake and drives one word-line bit-plane per cycle. It also generates the accumulator's start_acc pulse, aligned to the macro/global_io latency, and a result-valid pulse for the accumulator output nout.

---
 rtl/dcim_pkg.sv | 22 ++
 rtl/input_bit_serializer_if.sv | 16 +
 rtl/pulse_delay_line.sv | 38 +++
 rtl/input_bit_serializer.sv | 119 +++++++++++
 tb/tb_input_bit_serializer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dcim_pkg.sv
// Shared DCIM definitions: serializer FSM states, plane-counter width, default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcim_pkg;

  // Defaults shared by the serializer, accumulator and global_io.
  localparam int DEF_NUM_ROWS  = 64;
  localparam int DEF_ACT_WIDTH = 8;
  localparam int DEF_PSUM_LAT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } ser_state_e;

  // Plane counter width; a 1-bit activation still needs a 1-bit counter.
  function automatic int plane_cnt_w(input int act_width);
    return (act_width <= 1) ? 1 : $clog2(act_width);
  endfunction

endpackage

// File: rtl/input_bit_serializer_if.sv
// Activation vector channel into the serializer (valid/ready).
// Latency: n/a (wires only).
// Backpressure: producer holds act_valid/act_data/act_signed until act_ready.
// Ports: act_valid, act_ready, act_data (row r at [r*ACT_WIDTH +: ACT_WIDTH]), act_signed.
interface input_bit_serializer_if #(
  parameter int NUM_ROWS  = 64,
  parameter int ACT_WIDTH = 8
);
  logic                          act_valid;
  logic                          act_ready;
  logic [NUM_ROWS*ACT_WIDTH-1:0] act_data;
  logic                          act_signed;

  modport master (output act_valid, output act_data, output act_signed, input act_ready);
  modport slave  (input act_valid, input act_data, input act_signed, output act_ready);
endinterface

// File: rtl/pulse_delay_line.sv
// Delays single-cycle pulses by DEPTH cycles; several pulses may be in flight at once.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// Backpressure: none; every input pulse emerges exactly DEPTH cycles later.
// Ports: clk, rst_n (sync, active-low), in_pulse, out_pulse, pending (a pulse is stored).
module pulse_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_pulse,
  output logic out_pulse,
  output logic pending
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_pulse = in_pulse;
      assign pending   = 1'b0;
    end else begin : g_shift
      logic [DEPTH-1:0] sr;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sr <= '0;
        end else begin
          sr[0] <= in_pulse;
          for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end

      assign out_pulse = sr[DEPTH-1];
      assign pending   = |sr;
    end
  endgenerate

endmodule

// File: rtl/input_bit_serializer.sv
// Bit-serial activation feeder for the DCIM macro, MSB plane first, plus accumulator start/result pulses.
// Latency: first plane 2 cycles after handshake; start_acc at h+1+PSUM_LAT; nout_valid at h+ACT_WIDTH+PSUM_LAT+3.
// Backpressure: act_ready only in IDLE or on the last plane; back-to-back ops get one bubble cycle.
// Ports: clk, rst_n (sync, active-low), act (slave channel), wl_bits, wl_valid, msb_neg,
//        last_plane, start_acc, nout_valid, busy.
module input_bit_serializer
  import dcim_pkg::*;
#(
  parameter int NUM_ROWS  = DEF_NUM_ROWS,
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int PSUM_LAT  = DEF_PSUM_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input_bit_serializer_if.slave   act,
  output logic [NUM_ROWS-1:0]     wl_bits,
  output logic                    wl_valid,
  output logic                    msb_neg,
  output logic                    last_plane,
  output logic                    start_acc,
  output logic                    nout_valid,
  output logic                    busy
);

  localparam int            CW   = plane_cnt_w(ACT_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(ACT_WIDTH - 1);

  ser_state_e                    state, state_nxt;
  logic [CW-1:0]                 plane_cnt;
  logic [NUM_ROWS*ACT_WIDTH-1:0] shadow;
  logic                          shadow_signed;
  logic                          hs;
  logic                          start_pls;
  logic                          start_busy;
  logic                          nout_busy;
  logic [CW-1:0]                 bit_sel;

  assign hs = act.act_valid && act.act_ready;

  always_comb begin
    state_nxt     = state;
    act.act_ready = 1'b0;
    wl_valid      = 1'b0;
    msb_neg       = 1'b0;
    last_plane    = 1'b0;
    start_pls     = 1'b0;
    case (state)
      IDLE: begin
        act.act_ready = 1'b1;
        if (act.act_valid) state_nxt = START;
      end
      START: begin
        start_pls = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        wl_valid      = 1'b1;
        last_plane    = (plane_cnt == LAST);
        msb_neg       = shadow_signed && (plane_cnt == '0);
        // Accept the next vector during the final plane so only START separates ops.
        act.act_ready = last_plane;
        if (last_plane) state_nxt = act.act_valid ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      plane_cnt     <= '0;
      shadow        <= '0;
      shadow_signed <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        shadow        <= act.act_data;
        shadow_signed <= act.act_signed;
      end
      if (state == START) begin
        plane_cnt <= '0;
      end else if (state == SHIFT && !last_plane) begin
        plane_cnt <= plane_cnt + CW'(1);
      end
    end
  end

  // Plane k carries bit (ACT_WIDTH-1-k) of every row.
  assign bit_sel = LAST - plane_cnt;

  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      logic [ACT_WIDTH-1:0] row;
      assign row        = shadow[r*ACT_WIDTH +: ACT_WIDTH];
      assign wl_bits[r] = wl_valid & row[bit_sel];
    end
  endgenerate

  // start_acc lands the cycle before the first plane's psum reaches the accumulator.
  pulse_delay_line #(.DEPTH(PSUM_LAT)) u_start_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pulse  (start_pls),
    .out_pulse (start_acc),
    .pending   (start_busy)
  );

  // Two extra stages: acc_reg update, then nout capture.
  pulse_delay_line #(.DEPTH(PSUM_LAT + 2)) u_nout_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pulse  (last_plane),
    .out_pulse (nout_valid),
    .pending   (nout_busy)
  );

  assign busy = (state != IDLE) || start_busy || nout_busy;

endmodule

// File: tb/tb_input_bit_serializer.sv
// Directed, table-driven bench for input_bit_serializer (NUM_ROWS=4, ACT_WIDTH=4, PSUM_LAT=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_input_bit_serializer;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int PL = 2;

  typedef struct packed {
    logic       rdy;
    logic [3:0] wl;
    logic       wv;
    logic       msb;
    logic       last;
    logic       st;
    logic       nout;
    logic       bsy;
  } out_t;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        s;
    out_t        exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] wl_bits;
  logic          wl_valid, msb_neg, last_plane, start_acc, nout_valid, busy;

  input_bit_serializer_if #(.NUM_ROWS(NR), .ACT_WIDTH(AW)) act_if ();

  input_bit_serializer #(.NUM_ROWS(NR), .ACT_WIDTH(AW), .PSUM_LAT(PL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .act        (act_if.slave),
    .wl_bits    (wl_bits),
    .wl_valid   (wl_valid),
    .msb_neg    (msb_neg),
    .last_plane (last_plane),
    .start_acc  (start_acc),
    .nout_valid (nout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Rows {0xA,0x3,0xF,0x0} and {0x1,0x8,0x6,0xC}, row 0 in the low nibble.
  localparam logic [15:0] VEC_A = 16'h0F3A;
  localparam logic [15:0] VEC_B = 16'hC681;

  task automatic add(input logic v, input logic [15:0] d, input logic s,
                     input logic rdy, input logic [3:0] wl, input logic wv,
                     input logic msb, input logic last, input logic st,
                     input logic nout, input logic bsy);
    vec_t e;
    e.v        = v;
    e.d        = d;
    e.s        = s;
    e.exp.rdy  = rdy;
    e.exp.wl   = wl;
    e.exp.wv   = wv;
    e.exp.msb  = msb;
    e.exp.last = last;
    e.exp.st   = st;
    e.exp.nout = nout;
    e.exp.bsy  = bsy;
    tbl.push_back(e);
  endtask

  // One isolated op of VEC_A handshaken at its cycle 0, through fully idle (11 cycles).
  task automatic add_single(input logic s);
    add(1, VEC_A, s, 1, 4'h0, 0, 0, 0, 0, 0, 0); // c0 handshake
    add(0, 16'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1); // c1 START
    add(0, 16'h0, 0, 0, 4'h5, 1, s, 0, 0, 0, 1); // c2 plane 0
    add(0, 16'h0, 0, 0, 4'h4, 1, 0, 0, 1, 0, 1); // c3 plane 1, start_acc
    add(0, 16'h0, 0, 0, 4'h7, 1, 0, 0, 0, 0, 1); // c4 plane 2
    add(0, 16'h0, 0, 1, 4'h6, 1, 0, 1, 0, 0, 1); // c5 plane 3, last
    add(0, 16'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 1); // c6
    add(0, 16'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 1); // c7
    add(0, 16'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 1); // c8
    add(0, 16'h0, 0, 1, 4'h0, 0, 0, 0, 0, 1, 1); // c9 nout_valid
    add(0, 16'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0); // c10 idle
  endtask

  function automatic out_t sample();
    out_t o;
    o.rdy  = act_if.act_ready;
    o.wl   = wl_bits;
    o.wv   = wl_valid;
    o.msb  = msb_neg;
    o.last = last_plane;
    o.st   = start_acc;
    o.nout = nout_valid;
    o.bsy  = busy;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = sample();
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got rdy=%b wl=%h wv=%b msb=%b last=%b st=%b nout=%b busy=%b, want rdy=%b wl=%h wv=%b msb=%b last=%b st=%b nout=%b busy=%b",
               name, got.rdy, got.wl, got.wv, got.msb, got.last, got.st, got.nout, got.bsy,
               exp.rdy, exp.wl, exp.wv, exp.msb, exp.last, exp.st, exp.nout, exp.bsy);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic s);
    act_if.act_valid  = v;
    act_if.act_data   = d;
    act_if.act_signed = s;
  endtask

  // Inputs applied 1 time unit after posedge, outputs checked on the negedge.
  task automatic run_range(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].s);
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i - lo), tbl[i].exp);
      @(posedge clk);
      #1;
    end
  endtask

  out_t idle_o;
  out_t start_o;
  out_t p0_o;
  int   s1_lo, s2_lo, s3_lo, s4_lo, s4_hi;

  initial begin
    // Scenario 1: idle after reset.
    s1_lo = tbl.size();
    for (int i = 0; i < 5; i++) add(0, 16'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0);
    // Scenario 2/3: unsigned then signed single op.
    s2_lo = tbl.size();
    add_single(1'b0);
    s3_lo = tbl.size();
    add_single(1'b1);
    // Scenario 4 + 6: back-to-back, act_valid held with junk data while not ready.
    s4_lo = tbl.size();
    add(1, VEC_A,    0, 1, 4'h0, 0, 0, 0, 0, 0, 0); // c0 handshake A unsigned
    add(1, 16'hFFFF, 1, 0, 4'h0, 0, 0, 0, 0, 0, 1); // c1 START, junk ignored
    add(1, 16'h1234, 1, 0, 4'h5, 1, 0, 0, 0, 0, 1); // c2
    add(1, 16'h5555, 1, 0, 4'h4, 1, 0, 0, 1, 0, 1); // c3 start_acc
    add(1, 16'hAAAA, 0, 0, 4'h7, 1, 0, 0, 0, 0, 1); // c4
    add(1, VEC_B,    1, 1, 4'h6, 1, 0, 1, 0, 0, 1); // c5 handshake B signed on last plane
    add(1, 16'hFFFF, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1); // c6 bubble
    add(1, 16'h0000, 0, 0, 4'hA, 1, 1, 0, 0, 0, 1); // c7 sign plane of B
    add(1, 16'h3C3C, 0, 0, 4'hC, 1, 0, 0, 1, 0, 1); // c8 start_acc B
    add(1, 16'h7777, 1, 0, 4'h4, 1, 0, 0, 0, 1, 1); // c9 nout A
    add(0, 16'h0,    0, 1, 4'h1, 1, 0, 1, 0, 0, 1); // c10 last plane B
    add(0, 16'h0,    0, 1, 4'h0, 0, 0, 0, 0, 0, 1); // c11
    add(0, 16'h0,    0, 1, 4'h0, 0, 0, 0, 0, 0, 1); // c12
    add(0, 16'h0,    0, 1, 4'h0, 0, 0, 0, 0, 0, 1); // c13
    add(0, 16'h0,    0, 1, 4'h0, 0, 0, 0, 0, 1, 1); // c14 nout B
    add(0, 16'h0,    0, 1, 4'h0, 0, 0, 0, 0, 0, 0); // c15 idle
    s4_hi = tbl.size();

    idle_o  = '{rdy: 1'b1, wl: 4'h0, wv: 1'b0, msb: 1'b0, last: 1'b0, st: 1'b0, nout: 1'b0, bsy: 1'b0};
    start_o = '{rdy: 1'b0, wl: 4'h0, wv: 1'b0, msb: 1'b0, last: 1'b0, st: 1'b0, nout: 1'b0, bsy: 1'b1};
    p0_o    = '{rdy: 1'b0, wl: 4'h5, wv: 1'b1, msb: 1'b0, last: 1'b0, st: 1'b0, nout: 1'b0, bsy: 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_range(s1_lo, s2_lo, "reset_idle");
    run_range(s2_lo, s3_lo, "unsigned");
    run_range(s3_lo, s4_lo, "signed");
    run_range(s4_lo, s4_hi, "b2b");

    // Scenario 5: reset asserted in cycle 3 of an operation.
    drive(1'b1, VEC_A, 1'b0);
    @(negedge clk); check("rst_mid_c0", idle_o);
    @(posedge clk); #1;
    drive(1'b0, 16'h0, 1'b0);
    @(negedge clk); check("rst_mid_c1", start_o);
    @(posedge clk); #1;
    @(negedge clk); check("rst_mid_c2", p0_o);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); check($sformatf("rst_mid_after_c%0d", 4 + i), idle_o);
      @(posedge clk); #1;
    end
    run_range(s2_lo, s3_lo, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
